instr_mem_loadable: RTL and testbench
=====================================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised instruction store for the pipelined CPU. Feeds the fetch stage from a
//  synchronous-read array whose program is streamed in at run time over a valid/ready
//  load port, not fixed at elaboration. Adds fetch stall hold, a program-length bound
//  with NOP substitution, and a fault flag for fetches beyond the loaded program.
// PARAMETERS
//  WIDTH     32    instruction word width, bits
//  DEPTH     256   number of words; power of two, >= 2
//  NOP_WORD  0     word returned for out-of-range or bubble fetches
//  (local) AW = $clog2(DEPTH)
// PORTS
//  clock        in   1        rising-edge clock
//  reset_n      in   1        asynchronous active-low reset
//  load_start   in   1        pulse: begin (re)load at word 0
//  load_valid   in   1        load_data is valid this cycle
//  load_data    in   WIDTH    instruction word to store
//  load_last    in   1        qualifies final word of the program
//  load_ready   out  1        block accepts load words (high only in LOAD)
//  mem_ready    out  1        program loaded, fetches served (high only in READY)
//  prog_len     out  AW+1     number of words in the loaded program
//  fetch_req    in   1        fetch request
//  fetch_addr   in   AW       word address
//  fetch_stall  in   1        hold fetch outputs, ignore fetch_req
//  fetch_data   out  WIDTH    fetched word
//  fetch_valid  out  1        fetch_data valid
//  fetch_fault  out  1        fetched address >= prog_len (data = NOP_WORD)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, load ptr 0, prog_len 0, load_ready 0,
//   mem_ready 0, fetch_data NOP_WORD, fetch_valid 0, fetch_fault 0. Array not reset.
//  States: IDLE -load_start-> LOAD; LOAD -accepted last word-> READY;
//   READY -load_start-> LOAD; any state -load_start-> LOAD with ptr=0, prog_len=0.
//  Load: word accepted when load_valid & load_ready; written to mem[ptr], ptr+=1,
//   prog_len=ptr+1. Last word = load_last, or ptr==DEPTH-1 (implicit end, no
//   overflow wrap). load_start has priority over a same-cycle load_valid (word dropped).
//  Fetch: honoured only in READY with fetch_stall=0. fetch_req at edge N ->
//   edge N+1: fetch_valid=1; fetch_data=mem[fetch_addr], fetch_fault=0 if
//   fetch_addr<prog_len; else fetch_data=NOP_WORD, fetch_fault=1. Latency 1 cycle.
//  fetch_stall=1: fetch_data/valid/fault hold previous values; fetch_req ignored.
//  No stall, no honoured request (fetch_req=0 or not READY): fetch_valid=0,
//   fetch_fault=0, fetch_data=NOP_WORD next cycle.
//  load_start with fetch_req in READY: load wins; fetch not honoured.
//  Reset mid-load: returns to IDLE; partially written words unreachable (prog_len 0).
//  prog_len width AW+1 so a full array reports DEPTH exactly.
// TESTING
//  1 Reset then fetch_req addr 0 -> fetch_valid stays 0, fetch_data=0, mem_ready=0.
//  2 Load 3 words {0x71041000,0x510_4FC00,0x41420C00} last on 3rd -> prog_len=3,
//    mem_ready=1; fetch addr 1 -> next cycle fetch_data=0x5104FC00, valid=1, fault=0.
//  3 After test 2 fetch addr 5 -> fetch_data=0, fetch_valid=1, fetch_fault=1.
//  4 Fetch addr 0 then fetch_stall=1 for 3 cycles with fetch_req addr 2 -> outputs
//    hold 0x71041000 for all 3 cycles; stall drop + req addr 2 -> 0x41420C00 next.
//  5 Load DEPTH words without load_last -> implicit end, prog_len=DEPTH, READY;
//    extra load_valid ignored (load_ready=0); fetch addr DEPTH-1 returns final word.
//  6 reset_n pulsed low after 2 load words -> IDLE, prog_len=0, outputs at reset
//    values asynchronously; load_start+load_valid same cycle -> word dropped, ptr=0.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction store for the fetch stage.
// Program streams in over a valid/ready port; fetches are bounded by prog_len.
module instr_mem_loadable #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 256,
    parameter logic [WIDTH-1:0] NOP_WORD = '0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic             mem_ready,
    output logic [AW:0]      prog_len,
    input  logic             fetch_req,
    input  logic [AW-1:0]    fetch_addr,
    input  logic             fetch_stall,
    output logic [WIDTH-1:0] fetch_data,
    output logic             fetch_valid,
    output logic             fetch_fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]       state;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic accept;
    logic last_word;
    logic honour;
    logic in_range;

    assign load_ready = (state == S_LOAD);
    assign mem_ready  = (state == S_READY);

    // A restart drops any word presented in the same cycle.
    assign accept    = load_valid & load_ready & ~load_start;
    assign last_word = load_last | (ptr == AW'(DEPTH - 1));

    // A reload request takes precedence over a concurrent fetch.
    assign honour   = mem_ready & fetch_req & ~fetch_stall & ~load_start;
    assign in_range = ({1'b0, fetch_addr} < prog_len);

    // Load sequencing: state, write pointer and program length.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            prog_len <= '0;
        end else if (load_start) begin
            state    <= S_LOAD;
            ptr      <= '0;
            prog_len <= '0;
        end else if (accept) begin
            ptr      <= ptr + 1'b1;
            prog_len <= {1'b0, ptr} + 1'b1;
            if (last_word) begin
                state <= S_READY;
            end
        end
    end

    // Program array write port; contents are not cleared by reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[ptr] <= load_data;
        end
    end

    // Registered fetch port: hold on stall, NOP bubble when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_data  <= NOP_WORD;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (fetch_stall) begin
            fetch_data  <= fetch_data;
            fetch_valid <= fetch_valid;
            fetch_fault <= fetch_fault;
        end else if (honour) begin
            fetch_valid <= 1'b1;
            if (in_range) begin
                fetch_data  <= mem[fetch_addr];
                fetch_fault <= 1'b0;
            end else begin
                fetch_data  <= NOP_WORD;
                fetch_fault <= 1'b1;
            end
        end else begin
            fetch_data  <= NOP_WORD;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: directed stimulus with a queue-based fetch scoreboard.
// Expected fetch responses are queued by stimulus and popped by a monitor.
module tb_instr_mem_loadable;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             fault;
    } exp_t;

    logic             clock;
    logic             reset_n;
    logic             load_start;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic             load_ready;
    logic             mem_ready;
    logic [AW:0]      prog_len;
    logic             fetch_req;
    logic [AW-1:0]    fetch_addr;
    logic             fetch_stall;
    logic [WIDTH-1:0] fetch_data;
    logic             fetch_valid;
    logic             fetch_fault;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    instr_mem_loadable #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .NOP_WORD('0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_last(load_last),
        .load_ready(load_ready),
        .mem_ready(mem_ready),
        .prog_len(prog_len),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall),
        .fetch_data(fetch_data),
        .fetch_valid(fetch_valid),
        .fetch_fault(fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [WIDTH-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                         input logic f);
        exp_t e;
        e.data  = d;
        e.fault = f;
        exp_q.push_back(e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    // Monitor: every valid fetch output must match the oldest queued entry.
    always @(negedge clock) begin
        if (reset_n && fetch_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got 0x%08h fault %0d, none expected",
                         fetch_data, fetch_fault);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fetch_data", fetch_data, e.data);
                chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
        #12;
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_mem_ready", 32'(mem_ready), 0);
        chk("rst_prog_len", 32'(prog_len), 0);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_fetch_fault", 32'(fetch_fault), 0);
        reset_n = 1'b1;
        tick();

        // 1: fetch before any program is loaded is ignored
        fetch_req  = 1'b1;
        fetch_addr = '0;
        tick();
        fetch_req = 1'b0;
        chk("t1_valid", 32'(fetch_valid), 0);
        chk("t1_data", fetch_data, 0);
        chk("t1_mem_ready", 32'(mem_ready), 0);

        // 2: three-word program, fetch middle word
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t2_load_ready", 32'(load_ready), 1);
        load_word(32'h71041000, 1'b0);
        load_word(32'h5104FC00, 1'b0);
        load_word(32'h41420C00, 1'b1);
        chk("t2_prog_len", 32'(prog_len), 3);
        chk("t2_mem_ready", 32'(mem_ready), 1);
        chk("t2_load_ready_off", 32'(load_ready), 0);
        fetch(4'd1, 32'h5104FC00, 1'b0);
        tick();

        // 3: out-of-range fetches, including the first address past the end
        fetch(4'd5, 32'h0, 1'b1);
        fetch(4'd3, 32'h0, 1'b1);
        fetch(4'd2, 32'h41420C00, 1'b0);
        tick();

        // 4: stall holds outputs for three cycles and ignores the request
        fetch(4'd0, 32'h71041000, 1'b0);
        fetch_stall = 1'b1;
        fetch_req   = 1'b1;
        fetch_addr  = 4'd2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: 32'h71041000, fault: 1'b0});
            tick();
        end
        fetch_stall = 1'b0;
        fetch(4'd2, 32'h41420C00, 1'b0);
        tick();
        chk("t4_bubble_valid", 32'(fetch_valid), 0);

        // 5: fill the whole array without load_last
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            load_word(32'hA0000000 + 32'(i), 1'b0);
        end
        chk("t5_prog_len", 32'(prog_len), DEPTH);
        chk("t5_mem_ready", 32'(mem_ready), 1);
        chk("t5_load_ready", 32'(load_ready), 0);
        load_word(32'hDEADBEEF, 1'b0);
        chk("t5_prog_len_hold", 32'(prog_len), DEPTH);
        fetch(4'(DEPTH - 1), 32'hA000000F, 1'b0);
        fetch(4'd0, 32'hA0000000, 1'b0);
        tick();

        // 6: reload beats a fetch, then async reset mid-load
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("t6_load_ready", 32'(load_ready), 1);
        chk("t6_prog_len0", 32'(prog_len), 0);
        load_word(32'hB0000000, 1'b0);
        load_word(32'hB0000001, 1'b0);
        chk("t6_prog_len2", 32'(prog_len), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_load_ready", 32'(load_ready), 0);
        chk("t6_rst_prog_len", 32'(prog_len), 0);
        chk("t6_rst_mem_ready", 32'(mem_ready), 0);
        chk("t6_rst_fetch_data", fetch_data, 0);
        #2 reset_n = 1'b1;
        tick();
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        tick();
        fetch_req = 1'b0;
        chk("t6_idle_fetch", 32'(fetch_valid), 0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h11111111;
        tick();
        load_start = 1'b0;
        load_word(32'h22222222, 1'b1);
        chk("t6_prog_len1", 32'(prog_len), 1);
        chk("t6_mem_ready", 32'(mem_ready), 1);
        fetch(4'd0, 32'h22222222, 1'b0);
        fetch(4'd1, 32'h0, 1'b1);
        tick();
        tick();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
